fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have port clk  input  1  single rising-edge clock; all state updates on this edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall_f  input  1  hold fetch PC.
REQ-006 SHALL have port stall_d  input  1  hold IF/ID register.
REQ-007 SHALL have port flush_d  input  1  load bubble into IF/ID register.
REQ-008 SHALL have port pcsrc_e  input  1  taken branch/jump redirect from execute.
REQ-009 SHALL have port pctarget_e  input  32  redirect target from execute.
REQ-010 SHALL have port imem_addr  output  32  instruction memory address, equal to the fetch PC.
REQ-011 SHALL have port imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-012 SHALL have port instr_d  output  32  instruction to decode, feeding the immediate extender and the control decoder.
REQ-013 SHALL have port pc_d  output  32  PC of instr_d.
REQ-014 SHALL have port pcplus4_d  output  32  pc_d+4.
REQ-015 SHALL have port valid_d  output  1  instr_d is a real fetched instruction, not a bubble.

Function
REQ-016 SHALL hold fetch PC pc_f in a 32-bit register; imem_addr = pc_f combinationally.
REQ-017 SHALL compute next pc_f at each edge by priority: rst -> RESET_PC; pcsrc_e -> {pctarget_e[31:2],2'b00}; stall_f -> hold; else pc_f+4.
REQ-018 SHALL let redirect override stall_f when both are asserted in the same cycle.
REQ-019 SHALL wrap PC modulo 2^32: pc_f = 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
REQ-020 SHALL update the IF/ID register at each edge by priority: rst or flush_d -> bubble; stall_d -> hold all fields; else capture.
REQ-021 SHALL define bubble as instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0.
REQ-022 SHALL define capture as instr_d=imem_rdata, pc_d=pc_f, pcplus4_d=pc_f+4 (modulo 2^32), valid_d=1.
REQ-023 SHALL have fetch-to-decode latency of exactly one cycle: the word at imem_addr in cycle N appears on instr_d in cycle N+1.
REQ-024 SHALL let flush_d override stall_d when both are asserted.
REQ-025 SHALL treat stall_f and stall_d independently; the hazard unit is responsible for asserting them together.
REQ-026 SHALL have no combinational path from any input to instr_d, pc_d, pcplus4_d or valid_d.

Reset
REQ-027 SHALL, in the cycle after rst is sampled high, present pc_f=RESET_PC and the IF/ID register as bubble.
REQ-028 SHALL let rst take priority over stall, flush and redirect, including mid-stall and mid-redirect.
REQ-029 SHALL, in the first edge with rst low and no stall, capture the word at RESET_PC with valid_d=1.

Configuration
REQ-030 SHALL, when FETCH_PERF_CNT_EN is defined, add output ports stall_cnt (32) and flush_cnt (32).
REQ-031 SHALL, with FETCH_PERF_CNT_EN defined, increment stall_cnt on each edge with stall_d=1, flush_d=0 and rst=0.
REQ-032 SHALL, with FETCH_PERF_CNT_EN defined, increment flush_cnt on each edge with flush_d=1 and rst=0.
REQ-033 SHALL, with FETCH_PERF_CNT_EN defined, saturate both counters at 32'hFFFF_FFFF and clear them to 0 on rst.
REQ-034 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters, with all other behaviour identical.

Verification
REQ-035 SHALL cover reset then free run with imem[0]=32'h00500093: cycle 1 has instr_d=32'h00500093, pc_d=0, pcplus4_d=4, valid_d=1; imem_addr then steps 4, 8, 12.
REQ-036 SHALL cover stall_f=stall_d=1 for 2 cycles with pc_f=8: imem_addr stays 8 and instr_d/pc_d hold; after release, pc_d=8 on the next edge.
REQ-037 SHALL cover pcsrc_e=1, pctarget_e=32'h0000_0102, flush_d=1 in one cycle: next imem_addr=32'h0000_0100, instr_d=32'h00000013, valid_d=0.
REQ-038 SHALL cover pcsrc_e=1, stall_f=1, flush_d=1, stall_d=1 simultaneously: PC redirected and IF/ID bubbled.
REQ-039 SHALL cover pctarget_e=32'hFFFF_FFFC redirect then free run: pc_d=32'hFFFF_FFFC with pcplus4_d=0, then pc_d=0.
REQ-040 SHALL, with FETCH_PERF_CNT_EN defined, cover 3 stall cycles and 2 flush cycles: stall_cnt=3, flush_cnt=2; assert rst: both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch stage of a five-stage in-order pipeline. It owns the
//   fetch PC and drives the instruction memory address from it. It also owns
//   the IF/ID pipeline register that presents the fetched word, its PC and
//   PC+4 to decode.
//
// Ports:
//   clk         in   1   rising-edge clock; all state updates here
//   rst         in   1   synchronous, active-high reset
//   stall_f     in   1   hold the fetch PC
//   stall_d     in   1   hold the IF/ID register
//   flush_d     in   1   load a bubble into the IF/ID register
//   pcsrc_e     in   1   taken branch/jump redirect from execute
//   pctarget_e  in   32  redirect target (low two bits ignored)
//   imem_addr   out  32  instruction memory address (= fetch PC)
//   imem_rdata  in   32  instruction word, combinational read of imem_addr
//   instr_d     out  32  instruction to decode
//   pc_d        out  32  PC of instr_d
//   pcplus4_d   out  32  pc_d + 4
//   valid_d     out  1   instr_d is a real fetched instruction
//
// Configuration:
//   FETCH_PERF_CNT_EN  when defined, adds stall_cnt (32) and flush_cnt (32).
//                      These are saturating counters of decode stalls and
//                      flushes. Both clear on rst.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pcsrc_e,
    input  logic [31:0] pctarget_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        valid_d
);

    logic [31:0] pc_f_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;

    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pcplus4_d_r;
    logic        valid_d_r;

    // Sequential increment; the 32-bit add wraps FFFF_FFFC to 0 naturally.
    always_comb begin
        pc_plus4_s = pc_f_r + 32'd4;
    end

    // Next fetch PC: a redirect beats a stall, and a stall beats increment.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (pcsrc_e) begin
            pc_next_s = {pctarget_e[31:2], 2'b00};
        end else if (stall_f) begin
            pc_next_s = pc_f_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Fetch PC register; reset beats every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r <= RESET_PC;
        end else begin
            pc_f_r <= pc_next_s;
        end
    end

    // IF/ID register: a bubble on reset or flush, held on stall, else capture.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            instr_d_r   <= NOP_INSTR;
            pc_d_r      <= 32'h0000_0000;
            pcplus4_d_r <= 32'h0000_0000;
            valid_d_r   <= 1'b0;
        end else if (stall_d) begin
            instr_d_r   <= instr_d_r;
            pc_d_r      <= pc_d_r;
            pcplus4_d_r <= pcplus4_d_r;
            valid_d_r   <= valid_d_r;
        end else begin
            instr_d_r   <= imem_rdata;
            pc_d_r      <= pc_f_r;
            pcplus4_d_r <= pc_plus4_s;
            valid_d_r   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // A stall that coincides with a flush is counted only as a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (stall_d && !flush_d && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_d && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

    assign imem_addr = pc_f_r;
    assign instr_d   = instr_d_r;
    assign pc_d      = pc_d_r;
    assign pcplus4_d = pcplus4_d_r;
    assign valid_d   = valid_d_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed self-checking bench for fetch_stage. The instruction memory is a
// behavioural function of the address. Address 0 holds 32'h00500093. Every
// other address holds the address XOR 32'h1357_0000, so each fetched word
// identifies its own address. Define FETCH_PERF_CNT_EN to also exercise the
// performance counters.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks_s;
    int errors_s;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .valid_d    (valid_d)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0000) begin
            return 32'h0050_0093;
        end else begin
            return addr ^ 32'h1357_0000;
        end
    endfunction

    // Combinational instruction memory.
    assign imem_rdata = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s = checks_s + 1;
        if (got !== exp) begin
            errors_s = errors_s + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        pcsrc_e    = 1'b0;
        pctarget_e = 32'h0000_0000;
    endtask

    initial begin
        checks_s = 0;
        errors_s = 0;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        step();
        check_eq("rst_addr",   imem_addr, 32'h0000_0000);
        check_eq("rst_instr",  instr_d,   32'h0000_0013);
        check_eq("rst_pc",     pc_d,      32'h0000_0000);
        check_eq("rst_pc4",    pcplus4_d, 32'h0000_0000);
        check_eq("rst_valid",  {31'd0, valid_d}, 32'd1 - 32'd1);

        // Free run from reset
        rst = 1'b0;
        step();
        check_eq("run1_instr", instr_d,   32'h0050_0093);
        check_eq("run1_pc",    pc_d,      32'h0000_0000);
        check_eq("run1_pc4",   pcplus4_d, 32'h0000_0004);
        check_eq("run1_valid", {31'd0, valid_d}, 32'd1);
        check_eq("run1_addr",  imem_addr, 32'h0000_0004);
        step();
        check_eq("run2_addr",  imem_addr, 32'h0000_0008);
        check_eq("run2_pc",    pc_d,      32'h0000_0004);
        check_eq("run2_instr", instr_d,   32'h1357_0004);

        // Full stall for two cycles with pc_f = 8
        stall_f = 1'b1;
        stall_d = 1'b1;
        step();
        step();
        check_eq("stall_addr",  imem_addr, 32'h0000_0008);
        check_eq("stall_pc",    pc_d,      32'h0000_0004);
        check_eq("stall_instr", instr_d,   32'h1357_0004);
        idle_inputs();
        step();
        check_eq("rel_pc",    pc_d,      32'h0000_0008);
        check_eq("rel_instr", instr_d,   32'h1357_0008);
        check_eq("rel_addr",  imem_addr, 32'h0000_000C);

        // Redirect to an unaligned target together with a flush
        pcsrc_e    = 1'b1;
        pctarget_e = 32'h0000_0102;
        flush_d    = 1'b1;
        step();
        check_eq("redir_addr",  imem_addr, 32'h0000_0100);
        check_eq("redir_instr", instr_d,   32'h0000_0013);
        check_eq("redir_valid", {31'd0, valid_d}, 32'd0);
        check_eq("redir_pc",    pc_d,      32'h0000_0000);
        idle_inputs();
        step();
        check_eq("post_redir_pc",    pc_d,      32'h0000_0100);
        check_eq("post_redir_instr", instr_d,   32'h1357_0100);
        check_eq("post_redir_addr",  imem_addr, 32'h0000_0104);

        // Every control at once: redirect beats stall_f, flush beats stall_d
        pcsrc_e    = 1'b1;
        pctarget_e = 32'h0000_0200;
        stall_f    = 1'b1;
        flush_d    = 1'b1;
        stall_d    = 1'b1;
        step();
        check_eq("all_addr",  imem_addr, 32'h0000_0200);
        check_eq("all_instr", instr_d,   32'h0000_0013);
        check_eq("all_valid", {31'd0, valid_d}, 32'd0);

        // Decode stall alone: the PC keeps advancing and IF/ID holds
        idle_inputs();
        stall_d = 1'b1;
        step();
        check_eq("sd_addr",  imem_addr, 32'h0000_0204);
        check_eq("sd_valid", {31'd0, valid_d}, 32'd0);
        check_eq("sd_instr", instr_d,   32'h0000_0013);

        // Redirect to the top of the address space, then wrap
        idle_inputs();
        pcsrc_e    = 1'b1;
        pctarget_e = 32'hFFFF_FFFC;
        step();
        check_eq("wrap0_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wrap0_pc",   pc_d,      32'h0000_0204);
        idle_inputs();
        step();
        check_eq("wrap1_pc",   pc_d,      32'hFFFF_FFFC);
        check_eq("wrap1_pc4",  pcplus4_d, 32'h0000_0000);
        check_eq("wrap1_addr", imem_addr, 32'h0000_0000);
        step();
        check_eq("wrap2_pc",    pc_d,    32'h0000_0000);
        check_eq("wrap2_instr", instr_d, 32'h0050_0093);

        // Reset beats stall and redirect
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        pcsrc_e    = 1'b1;
        pctarget_e = 32'h0000_0400;
        rst        = 1'b1;
        step();
        check_eq("rstpri_addr",  imem_addr, 32'h0000_0000);
        check_eq("rstpri_valid", {31'd0, valid_d}, 32'd0);
        check_eq("rstpri_instr", instr_d,   32'h0000_0013);

`ifdef FETCH_PERF_CNT_EN
        check_eq("cnt_rst_stall", stall_cnt, 32'h0000_0000);
        check_eq("cnt_rst_flush", flush_cnt, 32'h0000_0000);
        idle_inputs();
        stall_d = 1'b1;
        step();
        step();
        step();
        idle_inputs();
        flush_d = 1'b1;
        step();
        // A flush together with a stall counts only as a flush
        stall_d = 1'b1;
        step();
        idle_inputs();
        step();
        check_eq("cnt_stall", stall_cnt, 32'h0000_0003);
        check_eq("cnt_flush", flush_cnt, 32'h0000_0002);
        rst = 1'b1;
        step();
        check_eq("cnt_clr_stall", stall_cnt, 32'h0000_0000);
        check_eq("cnt_clr_flush", flush_cnt, 32'h0000_0000);
        idle_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks_s, errors_s);
        $finish;
    end

endmodule
